// File: rtl/bp_pkg.sv
// Shared branch-predictor helpers: counter init/saturation and the gshare index hash.
// Functions take widths as arguments so any predictor table can reuse them.
package bp_pkg;

    typedef enum logic [0:0] {
        PHT_INIT,
        PHT_RUN
    } pht_state_e;

    // Weakly-taken value: only the MSB set.
    function automatic logic [31:0] ctr_init(input int ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c, input int ctr_w);
        logic [31:0] max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        return (c >= max_v) ? c : c + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] c);
        return (c == 32'd0) ? c : c - 32'd1;
    endfunction

    // Caller truncates the result to its own index width; history is zero-extended.
    function automatic logic [31:0] pht_hash(input logic [63:0] pc, input logic [31:0] hist,
                                             input int pc_shift);
        return 32'(pc >> pc_shift) ^ hist;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: counter storage, post-reset clearing sweep,
// asynchronous read port and a read-modify-write training port.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ready,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [CTR_W-1:0] mem [DEPTH];

    pht_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [CTR_W-1:0] wdata;
    logic [CTR_W-1:0] cur;

    // Reads see the pre-edge contents, so a same-cycle update is read-before-write.
    assign rd_ctr = mem[rd_idx];
    assign cur    = mem[wr_idx];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        waddr   = wr_idx;
        wdata   = cur;
        ready   = 1'b0;
        case (state_q)
            PHT_INIT: begin
                we    = 1'b1;
                waddr = ptr_q;
                wdata = CTR_W'(ctr_init(CTR_W));
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(DEPTH - 1)) state_d = PHT_RUN;
            end
            PHT_RUN: begin
                ready = 1'b1;
                we    = wr_en;
                wdata = wr_taken ? CTR_W'(sat_inc(32'(cur), CTR_W))
                                 : CTR_W'(sat_dec(32'(cur)));
            end
            default: state_d = PHT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PHT_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // No reset on the array so it can map onto RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: speculative GHR, one-cycle lookup response,
// PHT training on resolve and GHR repair on mispredict.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int PC_SHIFT  = 2,
    parameter int PHT_IDX_W = 10,
    parameter int HIST_LEN  = 8,
    parameter int CTR_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ready,
    input  logic                 pred_valid,
    input  logic [PC_WIDTH-1:0]  pred_pc,
    output logic                 resp_valid,
    output logic                 resp_taken,
    output logic [PHT_IDX_W-1:0] resp_idx,
    output logic [HIST_LEN-1:0]  resp_ghr,
    input  logic                 upd_valid,
    input  logic [PHT_IDX_W-1:0] upd_idx,
    input  logic [HIST_LEN-1:0]  upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict
);

    logic [HIST_LEN-1:0]  ghr_q, ghr_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_taken_q, resp_taken_d;
    logic [PHT_IDX_W-1:0] resp_idx_q, resp_idx_d;
    logic [HIST_LEN-1:0]  resp_ghr_q, resp_ghr_d;

    logic                 lookup;
    logic                 repair;
    logic [PHT_IDX_W-1:0] idx;
    logic [CTR_W-1:0]     rd_ctr;
    logic                 pred_dir;

    gshare_pht #(
        .IDX_W (PHT_IDX_W),
        .CTR_W (CTR_W)
    ) u_pht (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .rd_idx   (idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (upd_valid),
        .wr_idx   (upd_idx),
        .wr_taken (upd_taken)
    );

    assign idx      = PHT_IDX_W'(pht_hash(64'(pred_pc), 32'(ghr_q), PC_SHIFT));
    assign pred_dir = rd_ctr[CTR_W-1];

    always_comb begin
        lookup       = pred_valid && ready;
        repair       = upd_valid && upd_mispredict && ready;
        ghr_d        = ghr_q;
        resp_valid_d = lookup && !repair;
        resp_taken_d = resp_taken_q;
        resp_idx_d   = resp_idx_q;
        resp_ghr_d   = resp_ghr_q;
        if (lookup) begin
            resp_taken_d = pred_dir;
            resp_idx_d   = idx;
            resp_ghr_d   = ghr_q;
            ghr_d        = {ghr_q[HIST_LEN-2:0], pred_dir};
        end
        // Repair wins over the speculative shift of a lookup it squashes.
        if (repair) ghr_d = {upd_ghr[HIST_LEN-2:0], upd_taken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_idx_q   <= '0;
            resp_ghr_q   <= '0;
        end else begin
            ghr_q        <= ghr_d;
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
            resp_idx_q   <= resp_idx_d;
            resp_ghr_q   <= resp_ghr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_taken = resp_taken_q;
    assign resp_idx   = resp_idx_q;
    assign resp_ghr   = resp_ghr_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: a table/integer reference model queues
// expected responses; a negedge monitor pops and compares each DUT response.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        resp_valid;
    logic        resp_taken;
    logic [9:0]  resp_idx;
    logic [7:0]  resp_ghr;
    logic        upd_valid = 1'b0;
    logic [9:0]  upd_idx = '0;
    logic [7:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready          (ready),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .resp_valid     (resp_valid),
        .resp_taken     (resp_taken),
        .resp_idx       (resp_idx),
        .resp_ghr       (resp_ghr),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
    );

    typedef struct {
        int idx;
        int taken;
        int ghr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   m_pht[1024];
    int   m_ghr;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_pht[i] = 2;
        m_ghr = 0;
        q.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_unexpected: got response idx 0x%0h, expected none", resp_idx);
            end else begin
                mon_e = q.pop_front();
                check("resp_idx", int'(resp_idx), mon_e.idx);
                check("resp_taken", int'(resp_taken), mon_e.taken);
                check("resp_ghr", int'(resp_ghr), mon_e.ghr);
            end
        end
    end

    // One clock of stimulus; the model applies the same cycle's effects.
    task automatic cycle(input bit pv, input logic [31:0] pc, input bit uv, input int uidx,
                         input int ughr, input bit ut, input bit um);
        int idx, tk, ghr_n;
        exp_t e;
        pred_valid     = pv;
        pred_pc        = pc;
        upd_valid      = uv;
        upd_idx        = 10'(uidx);
        upd_ghr        = 8'(ughr);
        upd_taken      = ut;
        upd_mispredict = um;
        ghr_n = m_ghr;
        if (pv) begin
            idx = int'((pc >> 2) & 32'h3ff) ^ m_ghr;
            tk  = (m_pht[idx] >= 2) ? 1 : 0;
            if (!(uv && um)) begin
                e.idx = idx; e.taken = tk; e.ghr = m_ghr;
                q.push_back(e);
            end
            ghr_n = ((m_ghr * 2) + tk) % 256;
        end
        if (uv) begin
            if (ut) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
            else    m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
            if (um) ghr_n = ((ughr * 2) + int'(ut)) % 256;
        end
        m_ghr = ghr_n;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic lookup_idx(input int i);
        cycle(1'b1, 32'((i ^ m_ghr) & 1023) << 2, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic update(input int i, input bit t);
        cycle(1'b0, 32'd0, 1'b1, i, 0, t, 1'b0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n, 1024);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        check("drain_outstanding", q.size(), 0);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_ready", int'(ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_taken", int'(resp_taken), 0);
        check("rst_resp_idx", int'(resp_idx), 0);
        check("rst_resp_ghr", int'(resp_ghr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("ready_latency");

        // First lookup after the sweep
        cycle(1'b1, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
        // Saturate down then up on idx 0x010
        repeat (4) update('h10, 1'b0);
        lookup_idx('h10);
        repeat (4) update('h10, 1'b1);
        lookup_idx('h10);
        // Speculative history shift
        cycle(1'b1, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0);
        // Mispredict repair squashing a concurrent lookup
        cycle(1'b1, 32'h0, 1'b1, 'h33, 'hA5, 1'b0, 1'b1);
        cycle(1'b1, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
        // Read-before-write on the same index
        cycle(1'b1, 32'((32'h20 ^ m_ghr) & 1023) << 2, 1'b1, 'h20, 0, 1'b0, 1'b0);
        lookup_idx('h20);
        drain();

        for (int n = 0; n < 1500; n++) begin
            bit pv, uv, um;
            pv = ($urandom_range(0, 3) != 0);
            uv = ($urandom_range(0, 1) != 0);
            um = uv && ($urandom_range(0, 3) == 0);
            cycle(pv, 32'($urandom_range(0, 63)) << 2, uv, int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), um);
        end
        drain();

        // Reset in the middle of the sweep
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        repeat (500) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midsweep_ready", int'(ready), 0);
        check("midsweep_resp_valid", int'(resp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("ready_latency_restart");
        for (int i = 0; i < 1024; i++) lookup_idx(i);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
